// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: feeder FSM states, coin encodings
// (common with the vending controller) and the default item price.
package vm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COIN   = 3'd1,
    ST_GAP    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } feed_state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_HALF = 2'b01;
  localparam logic [1:0] COIN_ONE  = 2'b10;

  localparam int unsigned PRICE_HALF_DEF = 3;

  // Value of an encoded coin in half-yuan units.
  function automatic logic [3:0] coin_val(input logic [1:0] coin);
    case (coin)
      COIN_HALF: coin_val = 4'd1;
      COIN_ONE:  coin_val = 4'd2;
      default:   coin_val = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vm_edge_cnt.sv
// Registered rising-edge detector feeding a 4-bit saturating counter.
// cnt_nxt_o exposes the value the counter takes at the coming edge.
module vm_edge_cnt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sig_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [3:0] cnt_o,
  output logic [3:0] cnt_nxt_o
);

  logic       sig_q;
  logic [3:0] cnt_q, cnt_d;
  logic       rise;

  assign rise = sig_i & ~sig_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (en_i && rise && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      sig_q <= sig_i;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/vm_coin_feeder.sv
// Customer-side coin feeder: greedy coin pulses for a payment, then counts vend/change edges.
// Optional `VM_FEED_CHECK_EN builds a reference model that drives Mismatch; otherwise Mismatch=0.
module vm_coin_feeder
  import vm_pkg::*;
#(
  parameter int unsigned PRICE_HALF = PRICE_HALF_DEF,
  parameter int unsigned GAP_CYC    = 1,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req_valid,
  input  logic [3:0] Req_amt,
  output logic       Req_ready,
  output logic [1:0] Coin_out,
  input  logic       Vend_in,
  input  logic       Chg_in,
  output logic       Done,
  output logic [3:0] Vend_cnt,
  output logic [3:0] Chg_cnt,
  output logic       Mismatch
);

  feed_state_e state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic [3:0]  tmr_q, tmr_d;
  logic [1:0]  coin_q, coin_d;
  logic        done_q, done_d;
  logic        rdy_q, rdy_d;
  logic        accept;
  logic [3:0]  src_amt;
  logic        big_coin;
  logic        cnt_en;
  logic [3:0]  vend_nxt, chg_nxt;

  assign accept   = (state_q == ST_IDLE) && Req_valid;
  assign src_amt  = (state_q == ST_IDLE) ? Req_amt : rem_q;
  assign big_coin = (src_amt >= 4'd2);
  assign cnt_en   = (state_q == ST_COIN) || (state_q == ST_GAP) || (state_q == ST_SETTLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      rem_q   <= 4'd0;
      tmr_q   <= 4'd0;
      coin_q  <= COIN_NONE;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tmr_q   <= tmr_d;
      coin_q  <= coin_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (Req_amt != 4'd0) begin
            state_d = ST_COIN;
          end else begin
            state_d = ST_SETTLE;
            tmr_d   = 4'(SETTLE_CYC - 1);
          end
        end
      end
      ST_COIN: begin
        state_d = ST_GAP;
        tmr_d   = 4'(GAP_CYC - 1);
      end
      ST_GAP: begin
        if (tmr_q == 4'd0) begin
          if (rem_q != 4'd0) begin
            state_d = ST_COIN;
          end else begin
            state_d = ST_SETTLE;
            tmr_d   = 4'(SETTLE_CYC - 1);
          end
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // COIN lasts one cycle, so entering it is exactly when a coin is issued.
    if (state_d == ST_COIN) begin
      rem_d = src_amt - (big_coin ? 4'd2 : 4'd1);
    end
  end

  always_comb begin
    coin_d = COIN_NONE;
    if (state_d == ST_COIN) begin
      coin_d = big_coin ? COIN_ONE : COIN_HALF;
    end
    done_d = (state_d == ST_DONE);
    rdy_d  = (state_d == ST_IDLE);
  end

  vm_edge_cnt u_vend_cnt (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .sig_i     (Vend_in),
    .en_i      (cnt_en),
    .clr_i     (accept),
    .cnt_o     (Vend_cnt),
    .cnt_nxt_o (vend_nxt)
  );

  vm_edge_cnt u_chg_cnt (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .sig_i     (Chg_in),
    .en_i      (cnt_en),
    .clr_i     (accept),
    .cnt_o     (Chg_cnt),
    .cnt_nxt_o (chg_nxt)
  );

`ifdef VM_FEED_CHECK_EN
  logic [3:0] sum_q, sum_d;
  logic [3:0] ev_q, ev_d;
  logic [3:0] ec_q, ec_d;
  logic [4:0] sum_new;
  logic       mm_q, mm_d;

  always_comb begin
    sum_d   = accept ? 4'd0 : sum_q;
    ev_d    = accept ? 4'd0 : ev_q;
    ec_d    = accept ? 4'd0 : ec_q;
    sum_new = {1'b0, sum_d} + {1'b0, coin_val(coin_d)};
    if (coin_d != COIN_NONE) begin
      if (sum_new >= 5'(PRICE_HALF)) begin
        ev_d  = ev_d + 4'd1;
        if (sum_new > 5'(PRICE_HALF)) begin
          ec_d = ec_d + 4'd1;
        end
        sum_d = 4'd0;
      end else begin
        sum_d = sum_new[3:0];
      end
    end
    // Compare against the counts as they will stand while Done is high.
    mm_d = (state_d == ST_DONE) && ((vend_nxt != ev_q) || (chg_nxt != ec_q));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sum_q <= 4'd0;
      ev_q  <= 4'd0;
      ec_q  <= 4'd0;
      mm_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ev_q  <= ev_d;
      ec_q  <= ec_d;
      mm_q  <= mm_d;
    end
  end

  assign Mismatch = mm_q;
`else
  logic unused_chk;
  assign unused_chk = ^{vend_nxt, chg_nxt, 8'(PRICE_HALF)};
  assign Mismatch   = 1'b0;
`endif

  assign Req_ready = rdy_q;
  assign Coin_out  = coin_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_vm_coin_feeder.sv
// Scoreboard bench for vm_coin_feeder with a behavioural vending-controller responder.
module tb_vm_coin_feeder;
  import vm_pkg::*;

  localparam int G = 1;
  localparam int S = 4;

  logic       Clk = 1'b0;
  logic       Reset, Req_valid, Vend_in, Chg_in;
  logic [3:0] Req_amt;
  logic       Req_ready, Done, Mismatch;
  logic [1:0] Coin_out;
  logic [3:0] Vend_cnt, Chg_cnt;

  vm_coin_feeder #(.PRICE_HALF(3), .GAP_CYC(G), .SETTLE_CYC(S)) dut (
    .Clk(Clk), .Reset(Reset), .Req_valid(Req_valid), .Req_amt(Req_amt),
    .Req_ready(Req_ready), .Coin_out(Coin_out), .Vend_in(Vend_in), .Chg_in(Chg_in),
    .Done(Done), .Vend_cnt(Vend_cnt), .Chg_cnt(Chg_cnt), .Mismatch(Mismatch)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc = cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { int cyc; logic [1:0] coin; } coin_exp_t;
  typedef struct { int cyc; logic [3:0] v; logic [3:0] c; logic mm; } done_exp_t;
  coin_exp_t coin_q[$];
  done_exp_t done_q[$];
  bit stub_novend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Controller stand-in: answers one cycle after each coin; price is 3 half-yuan.
  int rs = 0;
  initial begin
    logic [1:0] c;
    logic       r;
    Vend_in = 1'b0;
    Chg_in  = 1'b0;
    forever begin
      @(negedge Clk);
      c = Coin_out;
      r = Reset;
      @(posedge Clk);
      #1;
      Vend_in = 1'b0;
      Chg_in  = 1'b0;
      if (r) begin
        rs = 0;
      end else if (c != COIN_NONE) begin
        rs += (c == COIN_ONE) ? 2 : 1;
        if (rs >= 3) begin
          Vend_in = !stub_novend;
          Chg_in  = (rs > 3);
          rs      = 0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a coin or Done.
  initial begin
    coin_exp_t ce;
    done_exp_t de;
    forever begin
      @(negedge Clk);
      if (Coin_out !== COIN_NONE) begin
        if (coin_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_coin: got %b expected none (cycle %0d)", Coin_out, cyc);
        end else begin
          ce = coin_q.pop_front();
          chk("coin_val", 32'(Coin_out), 32'(ce.coin));
          chk("coin_cyc", 32'(cyc), 32'(ce.cyc));
        end
      end
      if (Done !== 1'b0) begin
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got %b expected 0 (cycle %0d)", Done, cyc);
        end else begin
          de = done_q.pop_front();
          chk("done_cyc", 32'(cyc), 32'(de.cyc));
          chk("vend_cnt", 32'(Vend_cnt), 32'(de.v));
          chk("chg_cnt", 32'(Chg_cnt), 32'(de.c));
          chk("mismatch", 32'(Mismatch), 32'(de.mm));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Coins are packed first-coin-in-LSBs.
  task automatic issue(input logic [3:0] amt, input int n, input logic [15:0] coins,
                       input logic [3:0] ev, input logic [3:0] ec, input logic em,
                       input bit push_done, input bit hold, output int ta);
    int k;
    k = 0;
    while (Req_ready !== 1'b1 && k < 100) begin
      @(posedge Clk); #1; k++;
    end
    if (k >= 100) chk("ready_timeout", 32'(Req_ready), 32'd1);
    ta = cyc + 1;
    for (int i = 0; i < n; i++) coin_q.push_back('{ta + i * (G + 1), coins[2*i +: 2]});
    if (push_done) done_q.push_back('{ta + n * (G + 1) + S, ev, ec, em});
    Req_valid = 1'b1;
    Req_amt   = amt;
    @(posedge Clk); #1;
    if (hold) Req_amt = 4'd4;
    else      Req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((done_q.size() != 0 || coin_q.size() != 0) && k < 200) begin
      @(posedge Clk); #1; k++;
    end
    if (k >= 200) chk("done_timeout", 32'(done_q.size()), 32'd0);
    Req_valid = 1'b0;
  endtask

  int ta;
  logic em6;

  initial begin
    Reset = 1'b1; Req_valid = 1'b0; Req_amt = 4'd0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ready", 32'(Req_ready), 32'd1);
    chk("rst_coin", 32'(Coin_out), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_vend", 32'(Vend_cnt), 32'd0);
    chk("rst_chg", 32'(Chg_cnt), 32'd0);
    chk("rst_mm", 32'(Mismatch), 32'd0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // amount 3: one-yuan then half-yuan, exact price
    issue(4'd3, 2, {12'd0, COIN_HALF, COIN_ONE}, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, ta);
    wait_done();
    repeat (3) @(posedge Clk);
    #1;
    chk("hold_vend", 32'(Vend_cnt), 32'd1);
    chk("hold_chg", 32'(Chg_cnt), 32'd0);
    chk("idle_ready", 32'(Req_ready), 32'd1);

    issue(4'd4, 2, {12'd0, COIN_ONE, COIN_ONE}, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, ta);
    wait_done();

    issue(4'd7, 4, {8'd0, COIN_HALF, COIN_ONE, COIN_ONE, COIN_ONE}, 4'd2, 4'd1, 1'b0, 1'b1, 1'b0, ta);
    wait_done();
    repeat (2) @(posedge Clk);
    #1;
    chk("hold_vend7", 32'(Vend_cnt), 32'd2);

    // zero amount with Req_valid held through the busy period
    issue(4'd0, 0, 16'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, ta);
    wait_done();
    // amount 3 again, Req_amt changes to 4 while busy and must not be re-sampled
    issue(4'd3, 2, {12'd0, COIN_HALF, COIN_ONE}, 4'd1, 4'd0, 1'b0, 1'b1, 1'b1, ta);
    wait_done();
    repeat (4) @(posedge Clk);
    #1;
    chk("no_reaccept_ready", 32'(Req_ready), 32'd1);
    chk("no_reaccept_vend", 32'(Vend_cnt), 32'd1);

    // reset one cycle after the second coin of amount 7
    issue(4'd7, 2, {12'd0, COIN_ONE, COIN_ONE}, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, ta);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("rst5_coin", 32'(Coin_out), 32'd0);
    chk("rst5_ready", 32'(Req_ready), 32'd1);
    chk("rst5_vend", 32'(Vend_cnt), 32'd0);
    chk("rst5_chg", 32'(Chg_cnt), 32'd0);
    chk("rst5_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
    chk("rst5_coinq_empty", 32'(coin_q.size()), 32'd0);
    chk("rst5_idle", 32'(Req_ready), 32'd1);

    // responder never vends: checker (if built) must flag it
`ifdef VM_FEED_CHECK_EN
    em6 = 1'b1;
`else
    em6 = 1'b0;
`endif
    stub_novend = 1'b1;
    issue(4'd3, 2, {12'd0, COIN_HALF, COIN_ONE}, 4'd0, 4'd0, em6, 1'b1, 1'b0, ta);
    wait_done();
    stub_novend = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("end_coinq", 32'(coin_q.size()), 32'd0);
    chk("end_doneq", 32'(done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
